// File: rtl/lcd_line_sequencer.sv
// lcd_line_sequencer: scanline timing controller feeding the line renderer.
// Counts dots/lines, sequences PPU modes (OAM, draw, HBlank, VBlank), issues
// one drawline request per visible line and closes the loop on renderComplete.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   dot_en         dot tick; dot/line counting and mode changes advance only when high
//   lcd_enable     low forces OFF (mode 0, counters and overrun cleared)
//   lyc            LY compare value
//   stat_ie        STAT interrupt selects: [0] HBlank, [1] VBlank, [2] OAM, [3] LYC
//   renderComplete renderer finished the current line
//   drawline       request to draw line ly
//   ly             current line
//   mode           0 HBlank/OFF, 1 VBlank, 2 OAM, 3 draw
//   lyc_match      ly == lyc
//   vblank_irq     one-cycle pulse on VBlank entry
//   stat_irq       one-cycle pulse on a rising edge of the combined STAT line
//   frame_done     one-cycle pulse when the frame wraps to line 0
//   overrun        sticky: a line ended while still drawing
module lcd_line_sequencer #(
  parameter int unsigned DOTS_PER_LINE = 456,
  parameter int unsigned OAM_DOTS      = 80,
  parameter int unsigned MIN_DRAW_DOTS = 172,
  parameter int unsigned VISIBLE_LINES = 144,
  parameter int unsigned TOTAL_LINES   = 154
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dot_en,
  input  logic       lcd_enable,
  input  logic [7:0] lyc,
  input  logic [3:0] stat_ie,
  input  logic       renderComplete,
  output logic       drawline,
  output logic [7:0] ly,
  output logic [1:0] mode,
  output logic       lyc_match,
  output logic       vblank_irq,
  output logic       stat_irq,
  output logic       frame_done,
  output logic       overrun
);

  localparam int unsigned DOT_W = $clog2(DOTS_PER_LINE);
  localparam logic [DOT_W-1:0] DOT_LAST      = DOT_W'(DOTS_PER_LINE - 1);
  localparam logic [DOT_W-1:0] OAM_LAST      = DOT_W'(OAM_DOTS - 1);
  localparam logic [DOT_W-1:0] DRAW_MIN_LAST = DOT_W'(OAM_DOTS + MIN_DRAW_DOTS - 1);
  localparam logic [7:0]       VIS_LY        = 8'(VISIBLE_LINES);
  localparam logic [7:0]       LY_LAST       = 8'(TOTAL_LINES - 1);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_OAM    = 3'd1,
    S_DRAW   = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [DOT_W-1:0] dot, dot_d;
  logic [7:0]       ly_d, ly_inc;
  logic [1:0]       mode_d;
  logic             drawline_d;
  logic             done_latched, done_d;
  logic             overrun_d;
  logic             lyc_match_d;
  logic             vblank_irq_d, frame_done_d;
  logic             stat_line, stat_line_d, stat_irq_d;
  logic             render_done;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_OFF;
      dot          <= '0;
      ly           <= '0;
      mode         <= 2'd0;
      drawline     <= 1'b0;
      done_latched <= 1'b0;
      overrun      <= 1'b0;
      lyc_match    <= 1'b0;
      vblank_irq   <= 1'b0;
      frame_done   <= 1'b0;
      stat_line    <= 1'b0;
      stat_irq     <= 1'b0;
    end else begin
      state        <= state_d;
      dot          <= dot_d;
      ly           <= ly_d;
      mode         <= mode_d;
      drawline     <= drawline_d;
      done_latched <= done_d;
      overrun      <= overrun_d;
      lyc_match    <= lyc_match_d;
      vblank_irq   <= vblank_irq_d;
      frame_done   <= frame_done_d;
      stat_line    <= stat_line_d;
      stat_irq     <= stat_irq_d;
    end
  end

  // Next-state, counters, handshake and interrupt generation
  always_comb begin
    state_d      = state;
    dot_d        = dot;
    ly_d         = ly;
    drawline_d   = drawline;
    done_d       = done_latched;
    overrun_d    = overrun;
    vblank_irq_d = 1'b0;
    frame_done_d = 1'b0;
    mode_d       = 2'd0;
    ly_inc       = 8'(ly + 8'd1);
    // A completion arriving on the deciding edge counts the same as a latched one
    render_done  = done_latched | renderComplete;

    if (!lcd_enable) begin
      state_d    = S_OFF;
      dot_d      = '0;
      ly_d       = '0;
      drawline_d = 1'b0;
      done_d     = 1'b0;
      overrun_d  = 1'b0;
    end else if (state == S_OFF) begin
      state_d = S_OAM;
      dot_d   = '0;
      ly_d    = '0;
    end else begin
      // Handshake runs every clock, independent of dot_en
      if (state == S_DRAW && drawline && renderComplete) begin
        done_d     = 1'b1;
        drawline_d = 1'b0;
      end
      if (dot_en) begin
        if (dot == DOT_LAST) begin
          // Line end: a line still drawing is cut short and flagged
          dot_d      = '0;
          done_d     = 1'b0;
          drawline_d = 1'b0;
          if (state == S_DRAW && !render_done) overrun_d = 1'b1;
          if (ly == LY_LAST) begin
            ly_d         = '0;
            state_d      = S_OAM;
            frame_done_d = 1'b1;
          end else begin
            ly_d = ly_inc;
            if (ly_inc < VIS_LY) begin
              state_d = S_OAM;
            end else begin
              state_d      = S_VBLANK;
              vblank_irq_d = (ly_inc == VIS_LY);
            end
          end
        end else begin
          dot_d = DOT_W'(dot + 1'b1);
          case (state)
            S_OAM: begin
              if (dot == OAM_LAST) begin
                state_d    = S_DRAW;
                drawline_d = 1'b1;
              end
            end
            S_DRAW: begin
              if (render_done && dot >= DRAW_MIN_LAST) state_d = S_HBLANK;
            end
            default: ;
          endcase
        end
      end
    end

    case (state_d)
      S_VBLANK: mode_d = 2'd1;
      S_OAM:    mode_d = 2'd2;
      S_DRAW:   mode_d = 2'd3;
      default:  mode_d = 2'd0;
    endcase

    lyc_match_d = (ly_d == lyc);

    // STAT fires only on a rising edge of the OR of all enabled sources
    stat_line_d = ((mode_d == 2'd0) & stat_ie[0]) |
                  ((mode_d == 2'd1) & stat_ie[1]) |
                  ((mode_d == 2'd2) & stat_ie[2]) |
                  (lyc_match_d & stat_ie[3]);
    stat_irq_d  = stat_line_d & ~stat_line;
  end

endmodule

// File: tb/tb_lcd_line_sequencer.sv
// Bench for lcd_line_sequencer: directed timeline checks, a full frame with
// scripted/random render completions, then a randomized phase, all compared
// every cycle against a counter-based behavioural model.
module tb_lcd_line_sequencer;

  localparam int DPL = 456;
  localparam int OAM = 80;
  localparam int MIN_DRAW = 172;
  localparam int VIS = 144;
  localparam int TOT = 154;

  logic       clk = 1'b0;
  logic       reset;
  logic       dot_en, lcd_enable, renderComplete;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic       drawline;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       lyc_match, vblank_irq, stat_irq, frame_done, overrun;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  lcd_line_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .dot_en         (dot_en),
    .lcd_enable     (lcd_enable),
    .lyc            (lyc),
    .stat_ie        (stat_ie),
    .renderComplete (renderComplete),
    .drawline       (drawline),
    .ly             (ly),
    .mode           (mode),
    .lyc_match      (lyc_match),
    .vblank_irq     (vblank_irq),
    .stat_irq       (stat_irq),
    .frame_done     (frame_done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode is derived from the line/dot position and whether
  // the line has reached HBlank, rather than from an explicit state machine.
  bit m_on, m_done, m_hb, m_dl, m_ovr, m_lycm, m_vbl, m_fd, m_stat, m_sline;
  int m_dot, m_ly, m_mode;

  always @(posedge clk or negedge reset) begin : model
    bit in_draw, rdone, sl;
    if (!reset) begin
      m_on = 0; m_dot = 0; m_ly = 0; m_done = 0; m_hb = 0; m_dl = 0; m_ovr = 0;
      m_lycm = 0; m_vbl = 0; m_fd = 0; m_stat = 0; m_sline = 0; m_mode = 0;
    end else begin
      m_vbl = 0;
      m_fd  = 0;
      if (!lcd_enable) begin
        m_on = 0; m_dot = 0; m_ly = 0; m_done = 0; m_hb = 0; m_dl = 0; m_ovr = 0;
      end else if (!m_on) begin
        m_on = 1; m_dot = 0; m_ly = 0; m_done = 0; m_hb = 0;
      end else begin
        in_draw = (m_ly < VIS) && (m_dot >= OAM) && !m_hb;
        rdone   = m_done || renderComplete;
        if (in_draw && m_dl && renderComplete) begin
          m_done = 1;
          m_dl   = 0;
        end
        if (dot_en) begin
          if (m_dot == DPL - 1) begin
            if (in_draw && !rdone) m_ovr = 1;
            m_dot = 0; m_done = 0; m_hb = 0; m_dl = 0;
            m_ly  = (m_ly + 1) % TOT;
            m_fd  = (m_ly == 0);
            m_vbl = (m_ly == VIS);
          end else begin
            if (in_draw && rdone && m_dot >= OAM + MIN_DRAW - 1) m_hb = 1;
            m_dot++;
            if (m_ly < VIS && m_dot == OAM) m_dl = 1;
          end
        end
      end
      m_mode  = !m_on ? 0 : (m_ly >= VIS) ? 1 : (m_dot < OAM) ? 2 : m_hb ? 0 : 3;
      m_lycm  = (m_ly == int'(lyc));
      sl      = (m_mode == 0 && stat_ie[0]) || (m_mode == 1 && stat_ie[1]) ||
                (m_mode == 2 && stat_ie[2]) || (m_lycm && stat_ie[3]);
      m_stat  = sl && !m_sline;
      m_sline = sl;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("drawline",   32'(drawline),   32'(m_dl));
      cmp("ly",         32'(ly),         m_ly);
      cmp("mode",       32'(mode),       m_mode);
      cmp("vblank_irq", 32'(vblank_irq), 32'(m_vbl));
      cmp("stat_irq",   32'(stat_irq),   32'(m_stat));
      cmp("frame_done", 32'(frame_done), 32'(m_fd));
      cmp("overrun",    32'(overrun),    32'(m_ovr));
      if (reset) cmp("lyc_match", 32'(lyc_match), 32'(m_lycm));
    end
  end

  initial begin
    int tgt, pos, line, d, off_cnt;
    int vbl_cnt, vbl_pos, fd_cnt, fd_pos, dl_vb, mode_bad, s5_dot0, s6_hb;
    int stat_cnt[8];
    vbl_cnt = 0; vbl_pos = 0; fd_cnt = 0; fd_pos = 0; dl_vb = 0; mode_bad = 0;
    s5_dot0 = 0; s6_hb = 0; off_cnt = 0;
    for (int k = 0; k < 8; k++) stat_cnt[k] = 0;

    reset = 1'b1; dot_en = 1'b0; lcd_enable = 1'b0; renderComplete = 1'b0;
    lyc = 8'd0; stat_ie = 4'd0;
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    cmp("rst_drawline",   32'(drawline),   0);
    cmp("rst_ly",         32'(ly),         0);
    cmp("rst_mode",       32'(mode),       0);
    cmp("rst_overrun",    32'(overrun),    0);
    cmp("rst_vblank_irq", 32'(vblank_irq), 0);
    cmp("rst_stat_irq",   32'(stat_irq),   0);
    cmp("rst_frame_done", 32'(frame_done), 0);
    reset = 1'b1;
    @(negedge clk);
    cmp("off_lyc_match", 32'(lyc_match), 1);
    cmp("off_mode",      32'(mode),      0);

    // Normal line: completion 50 cycles after drawline rises
    lcd_enable = 1'b1; dot_en = 1'b1; lyc = 8'd200;
    @(negedge clk);
    cmp("on_mode", 32'(mode), 2);
    cmp("on_ly",   32'(ly),   0);
    repeat (79) @(negedge clk);
    cmp("dot79_mode",     32'(mode),     2);
    cmp("dot79_drawline", 32'(drawline), 0);
    @(negedge clk);
    cmp("dot80_mode",     32'(mode),     3);
    cmp("dot80_drawline", 32'(drawline), 1);
    repeat (50) @(negedge clk);
    cmp("dot130_drawline", 32'(drawline), 1);
    renderComplete = 1'b1;
    @(negedge clk);
    renderComplete = 1'b0;
    cmp("dot131_drawline", 32'(drawline), 0);
    cmp("dot131_mode",     32'(mode),     3);
    repeat (120) @(negedge clk);
    cmp("dot251_mode", 32'(mode), 3);
    @(negedge clk);
    cmp("dot252_mode", 32'(mode), 0);
    repeat (203) @(negedge clk);
    cmp("dot455_ly", 32'(ly), 0);
    @(negedge clk);
    cmp("line1_ly",   32'(ly),   1);
    cmp("line1_mode", 32'(mode), 2);

    // Slow render: completion at dot 300
    repeat (300) @(negedge clk);
    cmp("slow_dot300_mode", 32'(mode), 3);
    renderComplete = 1'b1;
    @(negedge clk);
    renderComplete = 1'b0;
    cmp("slow_dot301_mode",    32'(mode),    0);
    cmp("slow_overrun",        32'(overrun), 0);
    repeat (154) @(negedge clk);
    @(negedge clk);
    cmp("line2_ly", 32'(ly), 2);

    // Overrun: no completion at all
    repeat (455) @(negedge clk);
    cmp("ovr_dot455_mode",     32'(mode),     3);
    cmp("ovr_dot455_drawline", 32'(drawline), 1);
    @(negedge clk);
    cmp("ovr_line3_ly",       32'(ly),       3);
    cmp("ovr_line3_overrun",  32'(overrun),  1);
    cmp("ovr_line3_drawline", 32'(drawline), 0);
    cmp("ovr_line3_mode",     32'(mode),     2);

    // Reset asserted mid-draw clears immediately
    repeat (120) @(negedge clk);
    cmp("mid_draw_drawline", 32'(drawline), 1);
    cmp("mid_draw_overrun",  32'(overrun),  1);
    #2 reset = 1'b0;
    #1;
    cmp("async_rst_drawline", 32'(drawline), 0);
    cmp("async_rst_ly",       32'(ly),       0);
    cmp("async_rst_mode",     32'(mode),     0);
    cmp("async_rst_overrun",  32'(overrun),  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmp("post_rst_mode", 32'(mode), 2);
    cmp("post_rst_ly",   32'(ly),   0);

    // Full frame; lines 0..6 scripted for STAT blocking, later lines random
    lyc = 8'd5; stat_ie = 4'b1001; tgt = 100;
    for (int i = 0; i < TOT * DPL; i++) begin
      if (m_dot == 0) begin
        if (m_ly < 7) begin
          tgt = (m_ly == 4) ? 9999 : 100;
        end else begin
          tgt     = int'($urandom_range(80, 470));
          stat_ie = 4'($urandom);
          lyc     = 8'($urandom_range(0, 160));
        end
      end
      renderComplete = (m_dot == tgt) || (m_ly >= 7 && ($urandom % 64) == 0);
      @(negedge clk);
      pos  = i + 1;
      line = pos / DPL;
      d    = pos % DPL;
      if (stat_irq && line < 8) stat_cnt[line]++;
      if (stat_irq && line == 5 && d == 0) s5_dot0++;
      if (stat_irq && line == 6 && d == OAM + MIN_DRAW) s6_hb++;
      if (vblank_irq) begin vbl_cnt++; vbl_pos = pos; end
      if (frame_done) begin fd_cnt++;  fd_pos  = pos; end
      if (line >= VIS && line < TOT && drawline) dl_vb++;
      if (line >= VIS && line < TOT && mode != 2'd1) mode_bad++;
    end
    renderComplete = 1'b0;
    cmp("stat_line4_count",    stat_cnt[4], 0);
    cmp("stat_line5_count",    stat_cnt[5], 1);
    cmp("stat_line5_at_dot0",  s5_dot0,     1);
    cmp("stat_line6_count",    stat_cnt[6], 1);
    cmp("stat_line6_hblank",   s6_hb,       1);
    cmp("vblank_irq_count",    vbl_cnt,     1);
    cmp("vblank_irq_position", vbl_pos,     VIS * DPL);
    cmp("frame_done_count",    fd_cnt,      1);
    cmp("frame_done_position", fd_pos,      TOT * DPL);
    cmp("wrap_ly",             32'(ly),     0);
    cmp("vblank_drawline",     dl_vb,       0);
    cmp("vblank_mode",         mode_bad,    0);
    cmp("overrun_sticky",      32'(overrun), 1);

    // Randomized phase: gated dots, stray completions, LCD drops, one reset
    for (int i = 0; i < 6000; i++) begin
      dot_en         = ($urandom % 4) != 0;
      renderComplete = ($urandom % 8) == 0;
      if (i == 1500) off_cnt = 2;
      else if (off_cnt > 0) off_cnt--;
      else if (($urandom % 1200) == 0) off_cnt = int'($urandom_range(1, 3));
      lcd_enable = (off_cnt == 0);
      if (($urandom % 150) == 0) lyc = 8'($urandom_range(0, 12));
      if (($urandom % 100) == 0) stat_ie = 4'($urandom);
      if (i == 3002) reset = 1'b1;
      @(negedge clk);
      if (i == 3000) #2 reset = 1'b0;
    end

    chk_en = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
